// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a one-entry skid buffer, registered in_ready,
// bubble insertion on in_clear and a synchronous flush on Req.
module pipe_stage_skid #(
    parameter int          DATA_W    = 128,
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter logic [4:0]  CODE_NONE = 5'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Req,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_clear,
    input  logic [31:0]       in_pc,
    input  logic              in_bd,
    input  logic [4:0]        in_exc,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bubble,
    output logic [31:0]       out_pc,
    output logic              out_bd,
    output logic [4:0]        out_exc,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic              valid;
        logic              bubble;
        logic [31:0]       pc;
        logic              bd;
        logic [4:0]        exc;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t r_m, r_s;
    ent_t w_m_nxt, w_s_nxt, w_in;
    logic r_in_ready;
    logic w_in_xfer, w_out_xfer;

    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_out_xfer = r_m.valid && out_ready;

    // A cleared entry keeps pc/bd so exception reporting still has a valid PC.
    always_comb begin
        w_in.valid  = 1'b1;
        w_in.bubble = in_clear;
        w_in.pc     = in_pc;
        w_in.bd     = in_bd;
        w_in.exc    = in_clear ? CODE_NONE : in_exc;
        w_in.data   = in_clear ? '0 : in_data;
    end

    always_comb begin
        w_m_nxt = r_m;
        w_s_nxt = r_s;
        if (!r_m.valid || w_out_xfer) begin
            if (r_s.valid) begin
                w_m_nxt = r_s;
                if (w_in_xfer) w_s_nxt = w_in;
                else           w_s_nxt.valid = 1'b0;
            end else if (w_in_xfer) begin
                w_m_nxt = w_in;
            end else begin
                // Empty main keeps pc/bd/data visible but reports no exception.
                w_m_nxt.valid  = 1'b0;
                w_m_nxt.bubble = 1'b0;
                w_m_nxt.exc    = CODE_NONE;
            end
        end else if (w_in_xfer) begin
            w_s_nxt = w_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || Req) begin
            r_m.valid  <= 1'b0;
            r_m.bubble <= 1'b0;
            r_m.pc     <= PC_RESET;
            r_m.bd     <= 1'b0;
            r_m.exc    <= CODE_NONE;
            r_m.data   <= '0;
            r_s        <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_m        <= w_m_nxt;
            r_s        <= w_s_nxt;
            r_in_ready <= !w_s_nxt.valid;
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_m.valid;
    assign out_bubble = r_m.bubble;
    assign out_pc     = r_m.pc;
    assign out_bd     = r_m.bd;
    assign out_exc    = r_m.exc;
    assign out_data   = r_m.data;
    assign occupancy  = {1'b0, r_m.valid} + {1'b0, r_s.valid};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench: queue-based model of a 2-deep in-order stage, plus
// directed scenarios with literal expectations and a randomized phase.
module tb_pipe_stage_skid;

    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          reset, Req, in_valid, in_clear, in_bd, out_ready;
    logic [31:0]   in_pc;
    logic [4:0]    in_exc;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid, out_bubble, out_bd;
    logic [31:0]   out_pc;
    logic [4:0]    out_exc;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;

    int checks = 0;
    int errors = 0;

    pipe_stage_skid #(.DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .Req(Req),
        .in_valid(in_valid), .in_ready(in_ready), .in_clear(in_clear),
        .in_pc(in_pc), .in_bd(in_bd), .in_exc(in_exc), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_bubble(out_bubble),
        .out_pc(out_pc), .out_bd(out_bd), .out_exc(out_exc), .out_data(out_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the stage is an in-order queue holding at most two entries.
    typedef struct {
        logic          bubble;
        logic [31:0]   pc;
        logic          bd;
        logic [4:0]    exc;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          q[$];
    logic          m_init = 1'b0;
    logic [31:0]   shown_pc;
    logic          shown_bd;
    logic [DW-1:0] shown_data;

    always @(posedge clk) begin
        if (reset || Req) begin
            q.delete();
            shown_pc   = 32'h0000_3000;
            shown_bd   = 1'b0;
            shown_data = '0;
            if (reset) m_init = 1'b1;
        end else if (m_init) begin
            bit ox, ix;
            ent_t e;
            ox = (q.size() > 0) && out_ready;
            ix = in_valid && (q.size() < 2);
            if (ox) void'(q.pop_front());
            if (ix) begin
                e.bubble = in_clear;
                e.pc     = in_pc;
                e.bd     = in_bd;
                e.exc    = in_clear ? 5'd0 : in_exc;
                e.data   = in_clear ? '0 : in_data;
                q.push_back(e);
            end
            if (q.size() > 0) begin
                shown_pc   = q[0].pc;
                shown_bd   = q[0].bd;
                shown_data = q[0].data;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            bit ne;
            ne = q.size() > 0;
            chk("m_out_valid", out_valid, ne);
            chk("m_in_ready",  in_ready, q.size() < 2);
            chk("m_occupancy", occupancy, q.size());
            chk("m_out_pc",    out_pc, shown_pc);
            chk("m_out_bd",    out_bd, shown_bd);
            chk("m_out_data",  out_data, shown_data);
            chk("m_out_bubble", out_bubble, ne ? q[0].bubble : 1'b0);
            chk("m_out_exc",   out_exc, ne ? q[0].exc : 5'd0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc);
        in_valid = 1'b1; in_pc = pc; in_bd = 1'b0; in_exc = 5'd0;
        in_data = {96'd0, pc}; in_clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1; Req = 1'b0; in_valid = 1'b0; in_clear = 1'b0; in_bd = 1'b0;
        out_ready = 1'b0; in_pc = '0; in_exc = '0; in_data = '0;
        cyc(); cyc();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_pc", out_pc, 32'h3000);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_occ", occupancy, 2'd0);
        chk("rst_out_data", out_data, '0);
        reset = 1'b0;

        // Streaming with out_ready=1: one-cycle latency, skid unused
        out_ready = 1'b1;
        push(32'h3000); cyc(); chk("str_pc0", out_pc, 32'h3000); chk("str_v0", out_valid, 1'b1);
        push(32'h3004); cyc(); chk("str_pc1", out_pc, 32'h3004); chk("str_occ1", occupancy, 2'd1);
        push(32'h3008); cyc(); chk("str_pc2", out_pc, 32'h3008); chk("str_occ2", occupancy, 2'd1);
        in_valid = 1'b0; cyc();
        chk("str_empty", out_valid, 1'b0); chk("str_keep_pc", out_pc, 32'h3008);

        // Backpressure: fill both entries, third held upstream
        out_ready = 1'b0;
        push(32'h3000); cyc();
        push(32'h3004); cyc();
        chk("bp_occ", occupancy, 2'd2); chk("bp_rdy", in_ready, 1'b0);
        push(32'h3008); cyc();
        chk("bp_hold_pc", out_pc, 32'h3000);
        out_ready = 1'b1; cyc();
        chk("bp_out1", out_pc, 32'h3004);
        cyc();
        chk("bp_out2", out_pc, 32'h3008);
        in_valid = 1'b0; cyc();
        chk("bp_drained", out_valid, 1'b0);

        // Bubble insertion
        out_ready = 1'b0; in_valid = 1'b1; in_clear = 1'b1; in_pc = 32'h3010;
        in_bd = 1'b1; in_exc = 5'd4; in_data = '1;
        cyc();
        chk("clr_bubble", out_bubble, 1'b1); chk("clr_pc", out_pc, 32'h3010);
        chk("clr_bd", out_bd, 1'b1); chk("clr_exc", out_exc, 5'd0); chk("clr_data", out_data, '0);
        in_clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cyc();

        // Req flush with two entries held and input offered
        out_ready = 1'b0;
        push(32'h3014); cyc();
        push(32'h3018); cyc();
        chk("req_pre_occ", occupancy, 2'd2);
        Req = 1'b1; push(32'h3020); cyc();
        chk("req_valid", out_valid, 1'b0); chk("req_pc", out_pc, 32'h3000);
        chk("req_rdy", in_ready, 1'b1); chk("req_occ", occupancy, 2'd0);
        Req = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cyc(); chk("req_no_3020", out_valid, 1'b0);
        cyc(); chk("req_no_3020b", out_valid, 1'b0);

        // Reset and Req together with one entry held
        out_ready = 1'b0; push(32'h3030); cyc();
        chk("rr_pre_occ", occupancy, 2'd1);
        reset = 1'b1; Req = 1'b1; push(32'h3034); in_exc = 5'd7; cyc();
        chk("rr_valid", out_valid, 1'b0); chk("rr_pc", out_pc, 32'h3000);
        chk("rr_occ", occupancy, 2'd0); chk("rr_exc", out_exc, 5'd0);
        chk("rr_bd", out_bd, 1'b0); chk("rr_data", out_data, '0);
        reset = 1'b0; Req = 1'b0; in_valid = 1'b0;

        // Full stage with concurrent consume/offer, then drain (model checks order)
        push(32'h3100); cyc();
        push(32'h3104); cyc();
        chk("full_occ", occupancy, 2'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push(32'h3108 + 32'(i * 4)); cyc();
            if (!in_ready) begin push(32'h3108 + 32'(i * 4)); cyc(); end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        chk("full_drained", occupancy, 2'd0);

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            Req       = ($urandom_range(0, 49) == 0);
            in_valid  = $urandom_range(0, 3) != 0;
            in_clear  = $urandom_range(0, 5) == 0;
            out_ready = $urandom_range(0, 2) != 0;
            in_pc     = $urandom; in_bd = 1'(($urandom));
            in_exc    = 5'($urandom);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
